// File: rtl/poly_eval_pipe_if.sv
// poly_eval_pipe_if: sample stream and coefficient-write handshake bundle for poly_eval_pipe
interface poly_eval_pipe_if #(
  parameter int WIDTHIN = 16,
  parameter int WIDTHOUT = 32,
  parameter int AW = 3
);
  logic i_valid;
  logic o_ready;
  logic [WIDTHIN-1:0] i_x;
  logic o_valid;
  logic i_ready;
  logic [WIDTHOUT-1:0] o_y;
  logic i_coef_we;
  logic [AW-1:0] i_coef_addr;
  logic [WIDTHOUT-1:0] i_coef_data;
  logic o_coef_ack;
  modport slave (
    input i_valid, i_x, i_ready, i_coef_we, i_coef_addr, i_coef_data,
    output o_ready, o_valid, o_y, o_coef_ack
  );
  modport master (
    output i_valid, i_x, i_ready, i_coef_we, i_coef_addr, i_coef_data,
    input o_ready, o_valid, o_y, o_coef_ack
  );
endinterface

// File: rtl/poly_eval_pipe.sv
// poly_eval_pipe: pipelined Horner evaluator, Q2.14 in / Q7.25 out, runtime coefficients; define SATURATE_EN to clamp on overflow
module poly_eval_pipe #(
  parameter int ORDER = 5,
  parameter int WIDTHIN = 16,
  parameter int WIDTHOUT = 32,
  parameter int AW = 3
) (
  input logic clk,
  input logic reset_n,
  poly_eval_pipe_if.slave bus
);
  localparam int FB = WIDTHIN - 2;
  localparam int PW = WIDTHOUT + WIDTHIN;
  logic [WIDTHOUT-1:0] coef [0:ORDER];
  logic [WIDTHOUT-1:0] acc [1:ORDER];
  logic [WIDTHOUT-1:0] src [1:ORDER];
  logic [WIDTHOUT-1:0] nxt [1:ORDER];
  logic [WIDTHIN-1:0] xs [0:ORDER-1];
  logic [ORDER:0] v;
  logic [PW-1:0] prod;
  logic en, rdy, accept, wr, ack;
`ifdef SATURATE_EN
  localparam int SW = PW - FB + 1;
  logic [SW-1:0] sum;
  logic [ORDER:1] sat, sat_in, sat_nxt;
`endif

  function automatic logic [WIDTHOUT-1:0] dflt(input int k);
    return (k == 0 || k == 1) ? WIDTHOUT'(32'h0200_0000) :
           k == 2 ? WIDTHOUT'(32'h0100_0000) :
           k == 3 ? WIDTHOUT'(32'h0055_5555) :
           k == 4 ? WIDTHOUT'(32'h0015_5555) :
           k == 5 ? WIDTHOUT'(32'h0004_4444) : '0;
  endfunction

  assign en = !v[ORDER] | bus.i_ready;
  assign rdy = en & !bus.i_coef_we;
  assign accept = bus.i_valid & rdy;
  // a write lands only on an empty pipe so every sample sees one coefficient set
  assign wr = bus.i_coef_we & !ack & ~|v;
  assign bus.o_ready = rdy;
  assign bus.o_valid = v[ORDER];
  assign bus.o_y = acc[ORDER];
  assign bus.o_coef_ack = ack;

  always_comb begin
    prod = '0;
    src[1] = coef[ORDER];
    for (int k = 2; k <= ORDER; k++) src[k] = acc[k-1];
`ifdef SATURATE_EN
    sum = '0;
    sat_nxt = '0;
    sat_in[1] = 1'b0;
    for (int k = 2; k <= ORDER; k++) sat_in[k] = sat[k-1];
`endif
    for (int k = 1; k <= ORDER; k++) begin
      prod = PW'(src[k]) * PW'(xs[k-1]);
`ifdef SATURATE_EN
      sum = SW'(prod >> FB) + SW'(coef[ORDER-k]);
      sat_nxt[k] = sat_in[k] | (|sum[SW-1:WIDTHOUT]);
      nxt[k] = sat_nxt[k] ? '1 : sum[WIDTHOUT-1:0];
`else
      nxt[k] = WIDTHOUT'(prod >> FB) + coef[ORDER-k];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v <= '0;
      ack <= 1'b0;
      for (int k = 0; k <= ORDER; k++) coef[k] <= dflt(k);
      for (int k = 1; k <= ORDER; k++) acc[k] <= '0;
      for (int k = 0; k < ORDER; k++) xs[k] <= '0;
`ifdef SATURATE_EN
      sat <= '0;
`endif
    end else begin
      ack <= wr;
      if (wr && int'(bus.i_coef_addr) <= ORDER) coef[bus.i_coef_addr] <= bus.i_coef_data;
      if (en) v <= {v[ORDER-1:0], accept};
      if (accept) xs[0] <= bus.i_x;
      for (int k = 1; k <= ORDER; k++) begin
        if (en && v[k-1]) begin
          acc[k] <= nxt[k];
`ifdef SATURATE_EN
          sat[k] <= sat_nxt[k];
`endif
        end
      end
      for (int k = 1; k < ORDER; k++) if (en && v[k-1]) xs[k] <= xs[k-1];
    end
  end
endmodule

// File: tb/tb_poly_eval_pipe.sv
// tb_poly_eval_pipe: vector table plus scoreboard bench for poly_eval_pipe
module tb_poly_eval_pipe;
  localparam int ORDER = 5;
  localparam int WI = 16;
  localparam int WO = 32;
  localparam int AW = 3;

  typedef struct { logic [WI-1:0] x; logic [WO-1:0] y; } vec_t;
  typedef struct { logic [WO-1:0] y; logic [WI-1:0] x; bit tay; } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  poly_eval_pipe_if #(.WIDTHIN(WI), .WIDTHOUT(WO), .AW(AW)) ifc ();
  poly_eval_pipe #(.ORDER(ORDER), .WIDTHIN(WI), .WIDTHOUT(WO), .AW(AW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(ifc)
  );

  exp_t q[$];
  vec_t tbl[7];
  logic [WO-1:0] cm [0:ORDER];
  int n_cmp = 0;
  int n_bad = 0;
  bit accepted, ack_seen, prev_stall;
  logic [WO-1:0] prev_y;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_defaults();
    cm[0] = 32'h0200_0000;
    cm[1] = 32'h0200_0000;
    cm[2] = 32'h0100_0000;
    cm[3] = 32'h0055_5555;
    cm[4] = 32'h0015_5555;
    cm[5] = 32'h0004_4444;
  endtask

  function automatic logic [WO-1:0] model(input logic [WI-1:0] x);
    logic [63:0] a, s;
    bit st;
    st = 0;
    a = {32'b0, cm[ORDER]};
    for (int k = ORDER - 1; k >= 0; k--) begin
      s = ((a * {48'b0, x}) >> 14) + {32'b0, cm[k]};
`ifdef SATURATE_EN
      st = st | (s > 64'hFFFF_FFFF);
      a = st ? 64'hFFFF_FFFF : {32'b0, s[31:0]};
`else
      a = {32'b0, s[31:0]};
`endif
    end
    return a[31:0];
  endfunction

  function automatic real taylor(input logic [WI-1:0] x);
    real xr, t, s;
    xr = real'(x) / 16384.0;
    t = 1.0;
    s = 1.0;
    for (int k = 1; k <= 5; k++) begin
      t = t * xr / real'(k);
      s = s + t;
    end
    return s;
  endfunction

  logic [WO-1:0] nxt_exp;
  bit nxt_tay;

  task automatic tick();
    exp_t e;
    real yr, err;
    #1;
    accepted = ifc.i_valid & ifc.o_ready;
    if (prev_stall) begin
      check("stall_hold_valid", {63'b0, ifc.o_valid}, 64'd1);
      check("stall_hold_y", {32'b0, ifc.o_y}, {32'b0, prev_y});
    end
    if (ifc.o_valid & !ifc.i_ready) check("stall_ready", {63'b0, ifc.o_ready}, 64'd0);
    prev_stall = ifc.o_valid & !ifc.i_ready;
    prev_y = ifc.o_y;
    if (accepted) q.push_back('{nxt_exp, ifc.i_x, nxt_tay});
    if (ifc.o_valid & ifc.i_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h expected none", ifc.o_y);
      end else begin
        e = q.pop_front();
        check("result", {32'b0, ifc.o_y}, {32'b0, e.y});
        if (e.tay) begin
          yr = real'(ifc.o_y) / 33554432.0;
          err = yr - taylor(e.x);
          if (err < 0.0) err = -err;
          n_cmp++;
          if (err >= 0.045) begin
            n_bad++;
            $display("FAIL taylor x=%h: got %f expected %f", e.x, yr, taylor(e.x));
          end
        end
      end
    end
    if (ifc.o_coef_ack) begin
      ack_seen = 1;
      if (int'(ifc.i_coef_addr) <= ORDER) cm[ifc.i_coef_addr] = ifc.i_coef_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WI-1:0] x, input logic [WO-1:0] y, input bit tay);
    int n;
    ifc.i_valid = 1'b1;
    ifc.i_x = x;
    nxt_exp = y;
    nxt_tay = tay;
    n = 0;
    accepted = 0;
    while (!accepted && n < 50) begin
      tick();
      n++;
    end
    check("send_accepted", {63'b0, accepted}, 64'd1);
  endtask

  task automatic drain();
    int n;
    ifc.i_valid = 1'b0;
    ifc.i_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [WO-1:0] d);
    int n;
    ifc.i_coef_we = 1'b1;
    ifc.i_coef_addr = a;
    ifc.i_coef_data = d;
    #1;
    check("write_blocks_ready", {63'b0, ifc.o_ready}, 64'd0);
    tick();
    ifc.i_valid = 1'b0;
    ack_seen = 0;
    n = 0;
    while (!ack_seen && n < 60) begin
      tick();
      n++;
    end
    check("ack_seen", {63'b0, ack_seen}, 64'd1);
    check("drained_before_ack", 64'(q.size()), 64'd0);
    ifc.i_coef_we = 1'b0;
    check("ack_pulse", {63'b0, ifc.o_coef_ack}, 64'd0);
  endtask

  initial begin
    int n, sent;
    logic [WI-1:0] rx;
    ifc.i_valid = 1'b0;
    ifc.i_x = '0;
    ifc.i_ready = 1'b1;
    ifc.i_coef_we = 1'b0;
    ifc.i_coef_addr = '0;
    ifc.i_coef_data = '0;
    prev_stall = 0;
    set_defaults();
    tbl[0] = '{16'h0000, 32'h0200_0000};
    tbl[1] = '{16'h0002, 32'h0200_1000};
    tbl[2] = '{16'h4000, 32'h056E_EEEE};
    tbl[3] = '{16'hFFFF, model(16'hFFFF)};
    tbl[4] = '{16'h1234, model(16'h1234)};
    tbl[5] = '{16'h8000, model(16'h8000)};
    tbl[6] = '{16'h3FFF, model(16'h3FFF)};
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", {63'b0, ifc.o_valid}, 64'd0);
    check("rst_o_y", {32'b0, ifc.o_y}, 64'd0);
    check("rst_ack", {63'b0, ifc.o_coef_ack}, 64'd0);
    check("rst_o_ready", {63'b0, ifc.o_ready}, 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // single sample: latency in edges after the accept edge
    ifc.i_valid = 1'b1;
    ifc.i_x = 16'h0002;
    nxt_exp = 32'h0200_1000;
    nxt_tay = 1;
    tick();
    check("first_accept", {63'b0, accepted}, 64'd1);
    ifc.i_valid = 1'b0;
    n = 0;
    while (!ifc.o_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(ORDER));
    drain();
    for (int i = 0; i < 7; i++) begin
      ifc.i_valid = 1'b1;
      ifc.i_x = tbl[i].x;
      nxt_exp = tbl[i].y;
      nxt_tay = 1;
      tick();
      check("table_accept", {63'b0, accepted}, 64'd1);
    end
    drain();
    for (int i = 0; i < 50; i++) begin
      rx = 16'($urandom);
      ifc.i_valid = 1'b1;
      ifc.i_x = rx;
      nxt_exp = model(rx);
      nxt_tay = 1;
      tick();
      check("b2b_accept", {63'b0, accepted}, 64'd1);
    end
    drain();
    // downstream stall for 6 cycles once the pipe is full
    sent = 0;
    n = 0;
    while (sent < 12 && n < 60) begin
      rx = 16'($urandom);
      ifc.i_valid = 1'b1;
      ifc.i_x = rx;
      ifc.i_ready = !(n >= 7 && n < 13);
      nxt_exp = model(rx);
      nxt_tay = 1;
      tick();
      if (accepted) sent++;
      n++;
    end
    check("stall_sent", 64'(sent), 64'd12);
    drain();
    write_coef(3'd7, 32'h1234_5678);
    send(16'h4000, 32'h056E_EEEE, 1);
    drain();
    for (int i = 0; i < 3; i++) begin
      rx = 16'($urandom);
      send(rx, model(rx), 1);
    end
    write_coef(3'd5, 32'h7FFF_FFFF);
`ifdef SATURATE_EN
    send(16'hFFFF, 32'hFFFF_FFFF, 0);
`else
    send(16'hFFFF, model(16'hFFFF), 0);
`endif
    drain();
    // stray x while idle, then asynchronous reset with samples in flight
    send(16'h1000, model(16'h1000), 0);
    send(16'h2000, model(16'h2000), 0);
    ifc.i_valid = 1'b0;
    ifc.i_x = 16'd23;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", {63'b0, ifc.o_valid}, 64'd0);
    check("async_rst_y", {32'b0, ifc.o_y}, 64'd0);
    check("async_rst_ack", {63'b0, ifc.o_coef_ack}, 64'd0);
    q.delete();
    prev_stall = 0;
    set_defaults();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (8) tick();
    check("no_stray_output", {63'b0, ifc.o_valid}, 64'd0);
    send(16'h4000, 32'h056E_EEEE, 1);
    send(16'h0000, 32'h0200_0000, 1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
